// File: rtl/adder_arb_pkg.sv
// Shared types for the multi-word adder arbiter.
// Word width, word type and arbiter state encoding.
package adder_arb_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/adder_arbiter_prefix_adder.sv
// 16-bit Kogge-Stone prefix adder with carry in.
// Carry-in is folded into bit 0 generate so the tree yields true carries.
module PrefixAdder
    import adder_arb_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  cin,
    output word_t sum
);

    word_t p0, g0;
    word_t p1, g1;
    word_t p2, g2;
    word_t p3, g3;
    word_t g4;

    assign p0 = a ^ b;
    assign g0 = (a & b) | {{(WORD_W-1){1'b0}}, p0[0] & cin};

    assign g1 = g0 | (p0 & (g0 << 1));
    assign p1 = p0 & (p0 << 1);

    assign g2 = g1 | (p1 & (g1 << 2));
    assign p2 = p1 & (p1 << 2);

    assign g3 = g2 | (p2 & (g2 << 4));
    assign p3 = p2 & (p2 << 4);

    assign g4 = g3 | (p3 & (g3 << 8));

    assign sum = p0 ^ {g4[WORD_W-2:0], cin};

endmodule

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin search starting just above the pointer.
// The pointer position itself is searched last.
module rr_picker #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           any
);

    int t;

    // Walk from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        t      = 0;
        for (int k = N; k >= 1; k--) begin
            t = int'(ptr) + k;
            if (t >= N) t = t - N;
            if (req[IDW'(t)]) begin
                winner = IDW'(t);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one prefix adder between NREQ multi-word add/sub requesters.
// Grant is round-robin per transaction and held until the last word.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WORD_W-1:0]   req_a,
    input  logic [NREQ*WORD_W-1:0]   req_b,
    input  logic [NREQ-1:0]          req_sub,
    input  logic [NREQ-1:0]          req_last,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output word_t                    rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf,
    output logic                     rsp_last,
    output logic                     rsp_trunc
);

    localparam int   IDW      = $clog2(NREQ);
    localparam int   CNTW     = $clog2(MAX_WORDS + 1);
    localparam logic ONE_WORD = (MAX_WORDS == 1);

    typedef logic [IDW-1:0] id_t;

    arb_state_e      state;
    id_t             ptr;
    id_t             owner;
    id_t             pick;
    id_t             cur;
    logic            pick_any;
    logic [CNTW-1:0] cnt;
    logic            sub_r;
    logic            carry_r;

    word_t a_arr [NREQ];
    word_t b_arr [NREQ];

    logic  idle;
    logic  slot_free;
    logic  grant_ok;
    logic  accept;
    logic  sub_eff;
    logic  cin;
    logic  forced;
    logic  last_word;
    word_t a_w;
    word_t b_w;
    word_t bx;
    word_t sum;
    logic  c15;
    logic  cout;
    logic  ovf;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WORD_W +: WORD_W];
        assign b_arr[i] = req_b[i*WORD_W +: WORD_W];
    end

    rr_picker #(
        .N(NREQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .winner (pick),
        .any    (pick_any)
    );

    always_comb begin
        idle      = (state == ARB_IDLE);
        slot_free = !rsp_valid || rsp_ready;
        cur       = idle ? pick : owner;
        grant_ok  = idle ? pick_any : 1'b1;
        accept    = slot_free && grant_ok && req_valid[cur];
        req_ready = '0;
        req_ready[cur] = slot_free && grant_ok;
    end

    // Operation is latched on the first word; later words reuse sub_r.
    always_comb begin
        sub_eff   = idle ? req_sub[cur] : sub_r;
        cin       = idle ? sub_eff : carry_r;
        a_w       = a_arr[cur];
        b_w       = b_arr[cur];
        bx        = sub_eff ? ~b_w : b_w;
        forced    = idle ? ONE_WORD
                         : (cnt == CNTW'(MAX_WORDS - 1));
        last_word = req_last[cur] || forced;
    end

    PrefixAdder u_add (
        .a   (a_w),
        .b   (bx),
        .cin (cin),
        .sum (sum)
    );

    // Carry into bit 15 is recovered from the sum bit.
    assign c15  = sum[WORD_W-1] ^ a_w[WORD_W-1] ^ bx[WORD_W-1];
    assign cout = (a_w[WORD_W-1] & bx[WORD_W-1])
                | ((a_w[WORD_W-1] | bx[WORD_W-1]) & c15);
    assign ovf  = last_word
                && (a_w[WORD_W-1] == bx[WORD_W-1])
                && (sum[WORD_W-1] != a_w[WORD_W-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            ptr       <= id_t'(NREQ - 1);
            owner     <= '0;
            cnt       <= '0;
            sub_r     <= 1'b0;
            carry_r   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_trunc <= 1'b0;
        end else begin
            if (accept) begin
                carry_r   <= cout;
                rsp_valid <= 1'b1;
                rsp_id    <= cur;
                rsp_sum   <= sum;
                rsp_cout  <= cout;
                rsp_ovf   <= ovf;
                rsp_last  <= last_word;
                rsp_trunc <= forced && !req_last[cur];
                if (idle) begin
                    owner <= cur;
                    sub_r <= req_sub[cur];
                    cnt   <= CNTW'(1);
                end else begin
                    cnt <= cnt + CNTW'(1);
                end
                if (last_word) begin
                    ptr   <= cur;
                    state <= ARB_IDLE;
                end else begin
                    state <= ARB_LOCKED;
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: per-word expectations from a
// 17-bit reference add, plus grant-order checks from an id log.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int MAXW = 8;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        last;
        logic        trunc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic [NREQ-1:0]   req_last;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_sum;
    logic              rsp_cout;
    logic              rsp_ovf;
    logic              rsp_last;
    logic              rsp_trunc;

    logic        va [NREQ];
    logic [15:0] aa [NREQ];
    logic [15:0] ab [NREQ];
    logic        vs [NREQ];
    logic        vl [NREQ];

    logic [15:0] txa [NREQ][8];
    logic [15:0] txb [NREQ][8];

    exp_t exp_q [$];
    int   id_log [$];
    int   exp_ids [$];
    exp_t me;
    logic mon_en;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        req_last  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = va[i];
            req_a[i*16 +: 16]  = aa[i];
            req_b[i*16 +: 16]  = ab[i];
            req_sub[i]         = vs[i];
            req_last[i]        = vl[i];
        end
    end

    adder_arbiter #(
        .NREQ      (NREQ),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .rsp_last  (rsp_last),
        .rsp_trunc (rsp_trunc)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one transaction for requester r and pushes each word's
    // expected response at the edge where the word is accepted.
    task automatic drive_txn(input int r, input int n, input logic sub,
                             input logic mark_last);
        logic        carry;
        logic [16:0] s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] bx;
        logic        lw;
        exp_t        e;
        bit          hs;
        int          budget;
        carry = 1'b0;
        for (int k = 0; k < n; k++) begin
            a  = txa[r][k];
            b  = txb[r][k];
            bx = sub ? ~b : b;
            s  = {1'b0, a} + {1'b0, bx} + {16'b0, (k == 0) ? sub : carry};
            carry   = s[16];
            lw      = mark_last && (k == n - 1);
            e.id    = 2'(r);
            e.sum   = s[15:0];
            e.cout  = s[16];
            e.last  = lw || (k == MAXW - 1);
            e.trunc = (k == MAXW - 1) && !lw;
            e.ovf   = e.last && (a[15] == bx[15]) && (s[15] != a[15]);
            va[r] = 1'b1;
            aa[r] = a;
            ab[r] = b;
            vs[r] = (k == 0) ? sub : ~sub;
            vl[r] = lw;
            hs = 0;
            budget = 0;
            while (!hs && budget < 200) begin
                @(negedge clk);
                hs = req_ready[r];
                @(posedge clk);
                budget++;
            end
            if (!hs) begin
                check($sformatf("timeout_r%0d", r), 32'd0, 32'd1);
                va[r] = 1'b0;
                return;
            end
            exp_q.push_back(e);
            #1;
        end
        va[r] = 1'b0;
        vl[r] = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_ids(input string tag);
        check($sformatf("%s_cnt", tag), 32'(id_log.size()),
              32'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size(); i++) begin
            if (i < id_log.size())
                check($sformatf("%s_id%0d", tag, i), 32'(id_log[i]),
                      32'(exp_ids[i]));
        end
    endtask

    always @(negedge clk) begin
        if (!reset && mon_en && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                me = exp_q.pop_front();
                check("rsp_id",    32'(rsp_id),    32'(me.id));
                check("rsp_sum",   32'(rsp_sum),   32'(me.sum));
                check("rsp_cout",  32'(rsp_cout),  32'(me.cout));
                check("rsp_ovf",   32'(rsp_ovf),   32'(me.ovf));
                check("rsp_last",  32'(rsp_last),  32'(me.last));
                check("rsp_trunc", 32'(rsp_trunc), 32'(me.trunc));
                id_log.push_back(int'(rsp_id));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NREQ; r++) begin
            va[r] = 1'b0;
            aa[r] = '0;
            ab[r] = '0;
            vs[r] = 1'b0;
            vl[r] = 1'b0;
        end
        reset     = 1'b1;
        rsp_ready = 1'b1;
        mon_en    = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id",    32'(rsp_id),    32'd0);
        check("rst_sum",   32'(rsp_sum),   32'd0);
        check("rst_cout",  32'(rsp_cout),  32'd0);
        check("rst_ovf",   32'(rsp_ovf),   32'd0);
        check("rst_last",  32'(rsp_last),  32'd0);
        check("rst_trunc", 32'(rsp_trunc), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        for (int r = 0; r < NREQ; r++) begin
            for (int k = 0; k < 8; k++) begin
                txa[r][k] = 16'($urandom);
                txb[r][k] = 16'($urandom);
            end
        end

        // Round robin from reset: 0,1,2,3 then 0 again.
        id_log.delete();
        @(posedge clk);
        #1;
        fork
            begin
                drive_txn(0, 1, 1'b0, 1'b1);
                drive_txn(0, 1, 1'b1, 1'b1);
            end
            drive_txn(1, 1, 1'b0, 1'b1);
            drive_txn(2, 1, 1'b1, 1'b1);
            drive_txn(3, 1, 1'b0, 1'b1);
        join
        settle();
        exp_ids = {0, 1, 2, 3, 0};
        check_ids("rr");

        txa[0][0] = 16'h1234;
        txb[0][0] = 16'h0FFF;
        drive_txn(0, 1, 1'b0, 1'b1);

        txa[0][0] = 16'hFFFF;
        txa[0][1] = 16'h0001;
        txb[0][0] = 16'h0001;
        txb[0][1] = 16'h0000;
        drive_txn(0, 2, 1'b0, 1'b1);

        txa[0][0] = 16'h0005;
        txb[0][0] = 16'h0007;
        drive_txn(0, 1, 1'b1, 1'b1);
        txa[0][0] = 16'h8000;
        txb[0][0] = 16'h0001;
        drive_txn(0, 1, 1'b1, 1'b1);
        settle();

        // Locked 3-word subtract from requester 1 must not interleave.
        for (int k = 0; k < 3; k++) begin
            txa[1][k] = 16'($urandom);
            txb[1][k] = 16'($urandom);
        end
        txa[0][0] = 16'($urandom);
        txa[2][0] = 16'($urandom);
        id_log.delete();
        fork
            drive_txn(1, 3, 1'b1, 1'b1);
            drive_txn(0, 1, 1'b1, 1'b1);
            drive_txn(2, 1, 1'b0, 1'b1);
        join
        settle();
        exp_ids = {1, 1, 1, 2, 0};
        check_ids("lock");

        // Backpressure for 3 cycles while a 3-word add is in flight.
        txa[3][0] = 16'h1111;
        txa[3][1] = 16'h2222;
        txa[3][2] = 16'h3333;
        txb[3][0] = 16'h0101;
        txb[3][1] = 16'h0202;
        txb[3][2] = 16'h0303;
        rsp_ready = 1'b0;
        id_log.delete();
        fork
            drive_txn(3, 3, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", 32'(rsp_valid), 32'd1);
                    check("stall_sum",   32'(rsp_sum),   32'h1212);
                    check("stall_ready", 32'(req_ready), 32'd0);
                    @(posedge clk);
                end
                #1 rsp_ready = 1'b1;
            end
        join
        settle();
        exp_ids = {3, 3, 3};
        check_ids("stall");

        // Truncation at MAX_WORDS, then requester 2 must get the grant.
        for (int k = 0; k < 8; k++) begin
            txa[3][k] = 16'($urandom);
            txb[3][k] = 16'($urandom);
        end
        id_log.delete();
        fork
            drive_txn(3, 8, 1'b0, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                drive_txn(2, 1, 1'b0, 1'b1);
            end
        join
        settle();
        exp_ids = {3, 3, 3, 3, 3, 3, 3, 3, 2};
        check_ids("trunc");

        // Reset after the 2nd word of a 4-word transaction.
        mon_en = 1'b0;
        va[1] = 1'b1;
        aa[1] = 16'h4444;
        ab[1] = 16'h0404;
        vs[1] = 1'b0;
        vl[1] = 1'b0;
        @(negedge clk);
        check("rstx_w0_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstx_w1_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        va[1] = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstx_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        check("rstx_sb", 32'(exp_q.size()), 32'd0);
        id_log.delete();
        txa[0][0] = 16'($urandom);
        txa[2][0] = 16'($urandom);
        fork
            drive_txn(2, 1, 1'b0, 1'b1);
            drive_txn(0, 1, 1'b1, 1'b1);
        join
        settle();
        exp_ids = {0, 2};
        check_ids("rstx");

        check("sb_left", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
